// File: rtl/glip_uart_pkg.sv
// Shared constants and state encoding for the GLIP UART transmitter.
package glip_uart_pkg;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned DEFAULT_DIVISOR = 868;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StStart  = ST_START,
        StData   = ST_DATA,
        StParity = ST_PARITY,
        StStop   = ST_STOP
    } state_e;

endpackage

// File: rtl/glip_uart_baud_counter.sv
// Bit-period timer: tick pulses on the last clock cycle of every bit period.
module glip_uart_baud_counter
    import glip_uart_pkg::*;
#(
    parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear || count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/glip_uart_transmit.sv
// 8N1 UART transmitter, LSB first, with cts gating of frame starts.
// Define GLIP_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module glip_uart_transmit
    import glip_uart_pkg::*;
#(
    parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_enable,
    output logic       in_done,
    input  logic       cts,
    output logic       tx,
    output logic       busy
);

    state_e     state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_q;
    logic       tx_q;
    logic       tick;
    logic       start;
`ifdef GLIP_UART_TX_PARITY_EN
    logic       parity_q;
`endif

    assign start = (state_q == StIdle) && in_enable && cts;

    glip_uart_baud_counter #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
`ifdef GLIP_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        shift_q <= in_data;
                        state_q <= StStart;
                        tx_q    <= 1'b0;
`ifdef GLIP_UART_TX_PARITY_EN
                        parity_q <= ^in_data;
`endif
                    end
                end
                StStart: begin
                    if (tick) begin
                        state_q <= StData;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                StData: begin
                    // tx is registered, so it is loaded with the bit that becomes shift[0]
                    if (tick) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef GLIP_UART_TX_PARITY_EN
                            state_q <= StParity;
                            tx_q    <= parity_q;
`else
                            state_q <= StStop;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef GLIP_UART_TX_PARITY_EN
                StParity: begin
                    if (tick) begin
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (tick) begin
                        state_q <= StIdle;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign busy    = (state_q != StIdle);
    assign in_done = (state_q == StStop) && tick;

endmodule

// File: tb/tb_glip_uart_transmit.sv
// Self-checking bench for glip_uart_transmit: per-cycle frame model plus directed literal checks.
module tb_glip_uart_transmit;

    localparam int D = 4;
`ifdef GLIP_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FLEN = NB * D;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_enable = 1'b0;
    logic       cts = 1'b0;
    logic       in_done;
    logic       tx;
    logic       busy;

    int checks = 0;
    int failures = 0;

    glip_uart_transmit #(
        .DIVISOR (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_enable (in_enable),
        .in_done   (in_done),
        .cts       (cts),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a list of line levels, one per bit slot.
    function automatic logic [NB-1:0] make_frame(input logic [7:0] d);
        logic [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (NB == 11) f[9] = ^d;
        return f;
    endfunction

    // Model: a frame is a timer over FLEN cycles started by an idle-cycle request.
    bit            m_active = 1'b0;
    int            m_pos = 0;
    logic [NB-1:0] m_frame = '1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (in_enable && cts) begin
                m_active = 1'b1;
                m_pos = 0;
                m_frame = make_frame(in_data);
            end
        end else if (m_pos == FLEN - 1) begin
            m_active = 1'b0;
        end else begin
            m_pos++;
        end
    end

    always @(negedge clk) begin
        logic e_tx;
        e_tx = m_active ? m_frame[m_pos / D] : 1'b1;
        check("cyc_tx", 32'(tx), 32'(e_tx));
        check("cyc_busy", 32'(busy), 32'(m_active));
        check("cyc_done", 32'(in_done), 32'(m_active && m_pos == FLEN - 1));
    end

    task automatic drive(input logic [7:0] d, input logic en, input logic c);
        @(posedge clk);
        #2;
        in_data = d;
        in_enable = en;
        cts = c;
    endtask

    // Waits for a start bit, then decodes one frame sampling mid-bit on negedges.
    task automatic rx_frame(input bit drop, input int chg_pos, input logic [7:0] chg_val,
                            output logic [7:0] data, output logic par, output logic stop,
                            output int done_pos, output int busy_cyc, output int waited);
        bit found;
        found = 1'b0;
        waited = 0;
        data = '0;
        par = 1'b0;
        stop = 1'b0;
        done_pos = -1;
        busy_cyc = 0;
        for (int w = 0; w < 300 && !found; w++) begin
            @(negedge clk);
            waited++;
            if (tx === 1'b0) found = 1'b1;
        end
        if (!found) begin
            check("rx_start_timeout", 32'd0, 32'd1);
            return;
        end
        for (int p = 0; p < FLEN; p++) begin
            if (p > 0) @(negedge clk);
            if (p == chg_pos) in_data = chg_val;
            if (busy === 1'b1) busy_cyc++;
            if (in_done === 1'b1) begin
                done_pos = p;
                if (drop) in_enable = 1'b0;
            end
            if (p % D == D / 2) begin
                if (p / D >= 1 && p / D <= 8) data[p/D-1] = tx;
                if (NB == 11 && p / D == 9) par = tx;
                if (p / D == NB - 1) stop = tx;
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp;
        logic       rs;
        int         dp;
        int         bc;
        int         wt;
        int         cnt;

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

        // Single 0x55 frame
        drive(8'h55, 1'b1, 1'b1);
        rx_frame(1'b1, -1, 8'h00, rd, rp, rs, dp, bc, wt);
        check("f55_data", 32'(rd), 32'h55);
        check("f55_stop", 32'(rs), 32'd1);
        check("f55_done_pos", 32'(dp), 32'(FLEN - 1));
        check("f55_busy_cycles", 32'(bc), 32'(FLEN));
        check("f55_len_literal", 32'(FLEN), (NB == 11) ? 32'd44 : 32'd40);

        // Back-to-back 0xFE frames with in_enable held
        repeat (3) @(negedge clk);
        drive(8'hFE, 1'b1, 1'b1);
        cnt = 0;
        rx_frame(1'b0, -1, 8'h00, rd, rp, rs, dp, bc, wt);
        check("b2b_first_data", 32'(rd), 32'hFE);
        if (dp == FLEN - 1) cnt++;
        rx_frame(1'b1, -1, 8'h00, rd, rp, rs, dp, bc, wt);
        check("b2b_second_data", 32'(rd), 32'hFE);
        check("b2b_gap_high", 32'(D + wt - 1), 32'd5);
        if (dp == FLEN - 1) cnt++;
        check("b2b_done_pulses", 32'(cnt), 32'd2);
        cnt = 0;
        for (int i = 0; i < 3 * FLEN; i++) begin
            @(negedge clk);
            if (in_done === 1'b1 || tx === 1'b0) cnt++;
        end
        check("b2b_no_third", 32'(cnt), 32'd0);

        // cts held low blocks the frame
        drive(8'hA5, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) cnt++;
        end
        check("cts_hold_off", 32'(cnt), 32'd0);
        drive(8'hA5, 1'b1, 1'b1);
        rx_frame(1'b1, -1, 8'h00, rd, rp, rs, dp, bc, wt);
        check("cts_latency", 32'(wt), 32'd2);
        check("cts_data", 32'(rd), 32'hA5);

        // Reset during data bit 3 of 0x0F
        repeat (2) @(negedge clk);
        drive(8'h0F, 1'b1, 1'b1);
        cnt = 0;
        for (int w = 0; w < 20 && tx !== 1'b0; w++) @(negedge clk);
        repeat (17) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        in_enable = 1'b0;
        #1;
        check("rst_async_tx", 32'(tx), 32'd1);
        check("rst_async_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_done === 1'b1) cnt++;
        end
        check("rst_no_done", 32'(cnt), 32'd0);
        drive(8'h81, 1'b0, 1'b1);
        rst = 1'b1;
        drive(8'h81, 1'b1, 1'b1);
        rx_frame(1'b1, -1, 8'h00, rd, rp, rs, dp, bc, wt);
        check("post_rst_data", 32'(rd), 32'h81);
        check("post_rst_done_pos", 32'(dp), 32'(FLEN - 1));

        // in_data changes mid-frame
        repeat (2) @(negedge clk);
        drive(8'h3C, 1'b1, 1'b1);
        rx_frame(1'b1, 6, 8'hFF, rd, rp, rs, dp, bc, wt);
        check("stable_data", 32'(rd), 32'h3C);

`ifdef GLIP_UART_TX_PARITY_EN
        repeat (2) @(negedge clk);
        drive(8'h07, 1'b1, 1'b1);
        rx_frame(1'b1, -1, 8'h00, rd, rp, rs, dp, bc, wt);
        check("par_data", 32'(rd), 32'h07);
        check("par_bit", 32'(rp), 32'd1);
        check("par_done_pos", 32'(dp), 32'd43);
`endif

        // Random traffic: data churn, enable/cts toggling, rare async resets
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            in_data = 8'($urandom);
            in_enable = ($urandom_range(0, 9) < 7);
            cts = ($urandom_range(0, 9) < 8);
            rst = ($urandom_range(0, 499) != 0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        in_enable = 1'b0;
        repeat (2 * FLEN) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
